// File: rtl/rv32i_load_store_unit.sv
// RV32I load/store unit for the multicycle core's memory stage.
// Takes one request at a time and runs at most one data-bus transaction for it.
// Stores get lane-replicated write data and byte enables.
// Load results are sign- or zero-extended, then returned with a one-cycle done pulse.
// Misaligned accesses and the illegal size code finish at once with a fault and no bus activity.
module rv32i_load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_SIZE      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_store,
  input  logic [1:0]                i_req_size,
  input  logic                      i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0]     i_req_addr,
  input  logic [WORD_SIZE-1:0]      i_req_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] i_req_rd,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  output logic [WORD_SIZE-1:0]      o_mem_wdata,
  output logic [3:0]                o_mem_be,
  input  logic                      i_mem_gnt,
  input  logic                      i_mem_rvalid,
  input  logic [WORD_SIZE-1:0]      i_mem_rdata,
  output logic                      o_done,
  output logic                      o_fault,
  output logic                      o_wb_en,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_rd,
  output logic [WORD_SIZE-1:0]      o_wb_data
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      store_q, store_d;
  logic [1:0]                size_q, size_d;
  logic                      unsigned_q, unsigned_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [WORD_SIZE-1:0]      wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]      rdata_q, rdata_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      fault_q, fault_d;

  logic                      reqFault;
  logic [WORD_SIZE-1:0]      laneData;
  logic [3:0]                laneBe;
  logic [WORD_SIZE-1:0]      loadLane;
  logic [WORD_SIZE-1:0]      loadData;

  // Misalignment and illegal-size check on the incoming request
  always_comb begin
    reqFault = 1'b0;
    case (i_req_size)
      2'b00:   reqFault = 1'b0;
      2'b01:   reqFault = i_req_addr[0];
      2'b10:   reqFault = (i_req_addr[1:0] != 2'b00);
      default: reqFault = 1'b1;
    endcase
  end

  // State and latched request fields; the synchronous reset drops any transaction in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_q       <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_q       <= rd_d;
      fault_q    <= fault_d;
    end
  end

  // Next state: accept in IDLE, hold the bus request until granted, then wait for the response
  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_d       = rd_q;
    fault_d    = fault_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          store_d    = i_req_store;
          size_d     = i_req_size;
          unsigned_d = i_req_unsigned;
          addr_d     = i_req_addr;
          wdata_d    = i_req_wdata;
          rd_d       = i_req_rd;
          fault_d    = reqFault;
          rdata_d    = '0;
          state_d    = reqFault ? DONE : REQ;
        end
      end
      REQ: begin
        if (i_mem_gnt) begin
          if (i_mem_rvalid) begin
            rdata_d = i_mem_rdata;
            state_d = DONE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (i_mem_rvalid) begin
          rdata_d = i_mem_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store lane replication and byte enables; loads always read the whole word
  always_comb begin
    laneData = wdata_q;
    laneBe   = 4'b1111;
    case (size_q)
      2'b00: begin
        laneData = {4{wdata_q[7:0]}};
        if (store_q) laneBe = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        laneData = {2{wdata_q[15:0]}};
        if (store_q) laneBe = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        laneData = wdata_q;
        laneBe   = 4'b1111;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down, then sign- or zero-extend it
  always_comb begin
    loadLane = rdata_q >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   loadData = {{24{~unsigned_q & loadLane[7]}}, loadLane[7:0]};
      2'b01:   loadData = {{16{~unsigned_q & loadLane[15]}}, loadLane[15:0]};
      default: loadData = loadLane;
    endcase
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_mem_req   = (state_q == REQ);
  assign o_mem_we    = (state_q == REQ) & store_q;
  assign o_mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_wdata = laneData;
  assign o_mem_be    = (state_q == REQ) ? laneBe : 4'b0000;
  assign o_done      = (state_q == DONE);
  assign o_fault     = (state_q == DONE) & fault_q;
  assign o_wb_en     = (state_q == DONE) & ~store_q & ~fault_q & (rd_q != '0);
  assign o_wb_rd     = rd_q;
  assign o_wb_data   = (store_q | fault_q) ? '0 : loadData;

endmodule

// File: doc/rv32i_load_store_unit.md
Name: rv32I_load_store_unit

Overview:
- Memory-stage executor for the multicycle RV32I core.
- Consumes the memory-stage control produced by decode (load/store select, operand size, unsigned flag), the ALU-computed effective address, the store data and the destination register.
- Runs one data-bus transaction per request, with lane alignment and byte enables.
- Returns sign- or zero-extended load data to writeback, with a single-cycle done pulse.

Parameters:
- ADDR_WIDTH, 32, width of effective address and data-bus address.
- WORD_SIZE, 32, data width. Only 32 is supported.
- REG_ADDR_WIDTH, 5, destination register index width.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_req_valid  in  1  memory request from the execute stage.
- o_req_ready  out  1  high only in IDLE. A request is accepted when i_req_valid & o_req_ready.
- i_req_store  in  1  1 = store, 0 = load (the memory-op LSB from decode).
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- i_req_unsigned  in  1  zero-extend load data (LBU/LHU); ignored for stores.
- i_req_addr  in  ADDR_WIDTH  effective address.
- i_req_wdata  in  WORD_SIZE  store data (rs2).
- i_req_rd  in  REG_ADDR_WIDTH  load destination register.
- o_mem_req  out  1  bus request.
- o_mem_we  out  1  bus write enable.
- o_mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2], 2'b00}).
- o_mem_wdata  out  WORD_SIZE  lane-replicated store data.
- o_mem_be  out  4  byte enables.
- i_mem_gnt  in  1  request accepted by the bus.
- i_mem_rvalid  in  1  response valid (read data or write ack).
- i_mem_rdata  in  WORD_SIZE  read data.
- o_done  out  1  one-cycle completion pulse.
- o_fault  out  1  misaligned/illegal-size flag; valid only with o_done.
- o_wb_en  out  1  register write request; valid only with o_done.
- o_wb_rd  out  REG_ADDR_WIDTH  writeback register.
- o_wb_data  out  WORD_SIZE  extended load result.

Behaviour:
- Reset values:
  - State = IDLE.
  - o_req_ready = 1.
  - o_mem_req, o_mem_we, o_done, o_fault, o_wb_en = 0.
  - o_mem_be = 0; o_mem_addr, o_mem_wdata, o_wb_data, o_wb_rd = 0.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - On accept, latch all request fields.
  - Fault condition: size == 11, or half with addr[0] = 1, or word with addr[1:0] != 0.
  - Fault -> DONE with fault flag set; no bus activity.
  - Otherwise -> REQ.
- REQ:
  - Drive o_mem_req = 1 with addr/we/be/wdata held stable until i_mem_gnt.
  - gnt & rvalid in the same cycle -> DONE (capture rdata).
  - gnt only -> RESP.
  - No gnt -> stay in REQ, unlimited.
- RESP:
  - o_mem_req = 0.
  - On i_mem_rvalid, capture i_mem_rdata -> DONE.
  - Stores also wait for rvalid, which acts as the write ack.
- DONE:
  - o_done = 1 for exactly one cycle -> IDLE.
  - o_wb_en = load & ~fault & (rd != 0).
  - o_wb_rd = latched rd.
- Store lane rules:
  - byte: wdata = {4{wdata[7:0]}}, be = 4'b0001 << addr[1:0].
  - half: wdata = {2{wdata[15:0]}}, be = addr[1] ? 1100 : 0011.
  - word: be = 1111.
  - Loads drive be = 1111 and we = 0.
- Load extract:
  - lane = rdata >> (8*addr[1:0]).
  - byte: 8 bits, half: 16 bits, word: 32 bits.
  - Sign-extend from bit 7/15 unless unsigned.
- o_wb_data = 0 on store or fault.
- Latency (request accepted cycle T):
  - o_mem_req asserted T+1.
  - With gnt at T+1 and rvalid at T+2, o_done at T+3.
  - Minimum (gnt & rvalid at T+1): o_done at T+2.
  - Fault: o_done at T+1.
- i_mem_rvalid in IDLE/REQ-without-gnt/DONE is ignored.
- i_req_valid is ignored while o_req_ready = 0; the request must be held by the producer.
- Reset mid-transaction:
  - Immediate return to IDLE; o_mem_req drops the next cycle.
  - No o_done for the aborted request.
  - A late rvalid is ignored.

Test Plan:
- LW addr 0x100, gnt at T+1, rdata 0xDEADBEEF at T+2 -> o_mem_addr 0x100, be 1111, o_done at T+3, o_wb_data 0xDEADBEEF, o_wb_en 1.
- LB addr 0x203, rdata 0x80112233 -> wb_data 0xFFFFFF80. Same with LBU -> 0x00000080. LH addr 0x202 -> 0xFFFF8011.
- SB addr 0x41, wdata 0x000000A5 -> o_mem_we 1, addr 0x40, be 0010, wdata 0xA5A5A5A5, o_wb_en 0 at done. SH addr 0x42, wdata 0x1234 -> be 1100, wdata 0x12341234.
- LW addr 0x102; then SH addr 0x7; then size 11 -> each: no o_mem_req, o_done at T+1, o_fault 1, o_wb_en 0.
- gnt withheld 5 cycles -> addr/be/wdata stable and o_mem_req held 5 cycles. gnt & rvalid same cycle -> done next cycle. LW with rd = 0 -> o_wb_en 0.
- Reset in RESP, then rvalid 2 cycles later -> no o_done, o_req_ready 1, next LW completes normally.
